id_operand_stage: RTL and testbench

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

---
 rtl/id_operand_stage.sv | 150 +++++++++++++++
 tb/tb_id_operand_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// RV32I decode/operand stage: register read addressing, immediate generation,
// write-back bypass, load-use stall and a single registered ID/EX bundle.
module id_operand_stage #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADD_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_instr,
   input  logic [WIDTH-1:0]     in_pc,
   output logic [ADD_WIDTH-1:0] rs1_addr,
   output logic [ADD_WIDTH-1:0] rs2_addr,
   input  logic [WIDTH-1:0]     rs1_data,
   input  logic [WIDTH-1:0]     rs2_data,
   input  logic                 wb_en,
   input  logic [ADD_WIDTH-1:0] wb_rd,
   input  logic [WIDTH-1:0]     wb_data,
   input  logic                 ex_load,
   input  logic [ADD_WIDTH-1:0] ex_rd,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_pc,
   output logic [WIDTH-1:0]     out_instr,
   output logic [WIDTH-1:0]     out_op1,
   output logic [WIDTH-1:0]     out_op2,
   output logic [WIDTH-1:0]     out_imm,
   output logic [ADD_WIDTH-1:0] out_rd,
   output logic                 out_wen
);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [6:0]           w_opcode;
   logic [ADD_WIDTH-1:0] w_rd;
   logic                 w_rs1_used;
   logic                 w_rs2_used;
   logic [31:0]          w_imm32;
   logic [WIDTH-1:0]     w_imm;
   logic                 w_wen;
   logic [WIDTH-1:0]     w_op1;
   logic [WIDTH-1:0]     w_op2;
   logic                 w_hazard;
   logic                 w_can_load;

   logic                 r_valid;
   logic [WIDTH-1:0]     r_pc;
   logic [WIDTH-1:0]     r_instr;
   logic [WIDTH-1:0]     r_op1;
   logic [WIDTH-1:0]     r_op2;
   logic [WIDTH-1:0]     r_imm;
   logic [ADD_WIDTH-1:0] r_rd;
   logic                 r_wen;

   assign w_opcode = in_instr[6:0];
   assign rs1_addr = ADD_WIDTH'(in_instr[19:15]);
   assign rs2_addr = ADD_WIDTH'(in_instr[24:20]);
   assign w_rd     = ADD_WIDTH'(in_instr[11:7]);

   always_comb begin
      w_rs1_used = w_opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
      w_rs2_used = w_opcode inside {OP_REG, OP_STORE, OP_BRANCH};
      w_wen      = (w_rd != '0) &&
                   (w_opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
   end

   always_comb begin
      w_imm32 = '0;
      case (w_opcode)
         OP_IMM, OP_LOAD, OP_JALR:
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         OP_STORE:
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         OP_BRANCH:
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            w_imm32 = {in_instr[31:12], 12'b0};
         OP_JAL:
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
         default:
            w_imm32 = '0;
      endcase
   end

   // Replicate bit 31 (WIDTH-31) times so the extension is legal at WIDTH=32.
   assign w_imm = {{(WIDTH - 31){w_imm32[31]}}, w_imm32[30:0]};

   always_comb begin
      w_op1 = rs1_data;
      w_op2 = rs2_data;
      if (wb_en && (wb_rd != '0) && (wb_rd == rs1_addr)) w_op1 = wb_data;
      if (wb_en && (wb_rd != '0) && (wb_rd == rs2_addr)) w_op2 = wb_data;
   end

   assign w_hazard   = in_valid && ex_load && (ex_rd != '0) &&
                       ((w_rs1_used && (ex_rd == rs1_addr)) ||
                        (w_rs2_used && (ex_rd == rs2_addr)));
   assign w_can_load = out_ready || !r_valid;
   assign in_ready   = flush || (w_can_load && !w_hazard);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
         r_op1   <= '0;
         r_op2   <= '0;
         r_imm   <= '0;
         r_rd    <= '0;
         r_wen   <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_can_load && w_hazard) begin
         r_valid <= 1'b0;
      end else if (w_can_load) begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_pc    <= in_pc;
            r_instr <= in_instr;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_imm   <= w_imm;
            r_rd    <= w_rd;
            r_wen   <= w_wen;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign out_instr = r_instr;
   assign out_op1   = r_op1;
   assign out_op2   = r_op2;
   assign out_imm   = r_imm;
   assign out_rd    = r_rd;
   assign out_wen   = r_wen;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus randomized
// traffic compared against an arithmetic reference of the decode/stall rules.
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_load;
   logic [4:0]  ex_rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_op1;
   logic [31:0] out_op2;
   logic [31:0] out_imm;
   logic [4:0]  out_rd;
   logic        out_wen;

   int checks   = 0;
   int failures = 0;

   // Reference bundle state
   logic        m_valid;
   logic [31:0] m_pc, m_instr, m_op1, m_op2, m_imm;
   logic [4:0]  m_rd;
   logic        m_wen;

   localparam logic [31:0] I_ADDI = 32'h0070_0293;
   localparam logic [31:0] I_ADD  = 32'h0020_81B3;
   localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3;

   id_operand_stage #(.WIDTH(32), .ADD_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_instr(out_instr), .out_op1(out_op1), .out_op2(out_op2),
      .out_imm(out_imm), .out_rd(out_rd), .out_wen(out_wen)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f_imm(input logic [31:0] ins);
      int v;
      int sgn;
      sgn = ins[31] ? 1 : 0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: v = int'(ins[31:20]) - sgn * 4096;
         7'h23: v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
         7'h63: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                    - sgn * 4096;
         7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
         7'h6F: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                    - sgn * 1048576;
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic bit f_u1(input logic [31:0] ins);
      return ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
   endfunction

   function automatic bit f_u2(input logic [31:0] ins);
      return ins[6:0] inside {7'h33, 7'h23, 7'h63};
   endfunction

   function automatic bit f_wen(input logic [31:0] ins);
      return (ins[11:7] != 0) && (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67});
   endfunction

   function automatic bit f_hazard();
      return in_valid && ex_load && (ex_rd != 0) &&
             ((f_u1(in_instr) && ex_rd == in_instr[19:15]) ||
              (f_u2(in_instr) && ex_rd == in_instr[24:20]));
   endfunction

   function automatic bit f_ready();
      return flush || ((out_ready || !m_valid) && !f_hazard());
   endfunction

   // Advances the reference across one rising edge using the current inputs.
   task automatic clock_edge();
      logic        n_valid;
      logic [31:0] n_pc, n_instr, n_op1, n_op2, n_imm;
      logic [4:0]  n_rd;
      logic        n_wen;
      bit          can;
      n_valid = m_valid; n_pc = m_pc; n_instr = m_instr; n_op1 = m_op1;
      n_op2 = m_op2; n_imm = m_imm; n_rd = m_rd; n_wen = m_wen;
      can = out_ready || !m_valid;
      if (!rst_n) begin
         n_valid = 0; n_pc = 0; n_instr = 0; n_op1 = 0; n_op2 = 0; n_imm = 0; n_rd = 0; n_wen = 0;
      end else if (flush || (can && f_hazard())) begin
         n_valid = 0;
      end else if (can) begin
         n_valid = in_valid;
         if (in_valid) begin
            n_pc    = in_pc;
            n_instr = in_instr;
            n_op1   = (wb_en && wb_rd != 0 && wb_rd == in_instr[19:15]) ? wb_data : rs1_data;
            n_op2   = (wb_en && wb_rd != 0 && wb_rd == in_instr[24:20]) ? wb_data : rs2_data;
            n_imm   = f_imm(in_instr);
            n_rd    = in_instr[11:7];
            n_wen   = f_wen(in_instr);
         end
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_pc = n_pc; m_instr = n_instr; m_op1 = n_op1;
      m_op2 = n_op2; m_imm = n_imm; m_rd = n_rd; m_wen = n_wen;
   endtask

   task automatic model_clear();
      m_valid = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_wen = 0;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_instr = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
      wb_en = 0; wb_rd = 0; wb_data = 0; ex_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      model_clear();
      clock_edge();
      clock_edge();
      checks++;
      if ({out_valid, out_wen, out_rd} !== 7'd0 || {out_pc, out_instr, out_op1, out_op2, out_imm} !== 160'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b wen=%b rd=%0d pc=%h instr=%h required all zero",
                  out_valid, out_wen, out_rd, out_pc, out_instr);
      end
      #1 rst_n = 1;
   endtask

   task automatic test_addi();
      in_valid = 1; in_instr = I_ADDI; in_pc = 32'h100; out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || rs1_addr !== 5'd0) begin
         failures++;
         $display("FAIL addi_accept: in_ready=%b rs1_addr=%0d required 1/0", in_ready, rs1_addr);
      end
      clock_edge();
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_imm !== 32'd7 || out_wen !== 1'b1 || out_pc !== 32'h100) begin
         failures++;
         $display("FAIL addi_bundle: valid=%b rd=%0d imm=%h wen=%b pc=%h required 1/5/7/1/100",
                  out_valid, out_rd, out_imm, out_wen, out_pc);
      end
   endtask

   task automatic test_bypass();
      in_valid = 1; in_instr = I_ADD; in_pc = 32'h104;
      rs1_data = 32'h10; rs2_data = 32'h20; wb_en = 1; wb_rd = 2; wb_data = 32'hAA;
      #1;
      checks++;
      if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
         failures++;
         $display("FAIL add_addr: rs1=%0d rs2=%0d required 1/2", rs1_addr, rs2_addr);
      end
      clock_edge();
      checks++;
      if (out_op1 !== 32'h10 || out_op2 !== 32'hAA || out_imm !== 32'd0 || out_rd !== 5'd3) begin
         failures++;
         $display("FAIL wb_bypass: op1=%h op2=%h imm=%h rd=%0d required 10/aa/0/3",
                  out_op1, out_op2, out_imm, out_rd);
      end
      wb_en = 0;
   endtask

   task automatic test_load_use();
      in_valid = 1; in_instr = I_ADD; in_pc = 32'h108; out_ready = 1;
      ex_load = 1; ex_rd = 1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_use_ready: in_ready=%b required 0", in_ready);
      end
      clock_edge();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL load_use_bubble: out_valid=%b required 0", out_valid);
      end
      ex_load = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_use_release: in_ready=%b required 1", in_ready);
      end
      clock_edge();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_instr !== I_ADD) begin
         failures++;
         $display("FAIL load_use_accept: valid=%b pc=%h instr=%h required 1/108/%h",
                  out_valid, out_pc, out_instr, I_ADD);
      end
   endtask

   task automatic test_hold();
      in_valid = 1; in_instr = I_ADDI; in_pc = 32'h200; out_ready = 1;
      clock_edge();
      out_ready = 0; in_instr = I_BEQ; in_pc = 32'h204; rs1_data = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_ready[%0d]: in_ready=%b required 0", i, in_ready);
         end
         clock_edge();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== I_ADDI || out_imm !== 32'd7 || out_rd !== 5'd5) begin
            failures++;
            $display("FAIL hold_bundle[%0d]: valid=%b pc=%h instr=%h imm=%h required 1/200/%h/7",
                     i, out_valid, out_pc, out_instr, out_imm, I_ADDI);
         end
      end
   endtask

   task automatic test_flush();
      // Bundle is still held (out_ready=0) from the previous scenario.
      in_valid = 1; in_instr = I_ADD; ex_load = 1; ex_rd = 1; flush = 1; out_ready = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_ready: in_ready=%b required 1", in_ready);
      end
      clock_edge();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_valid: out_valid=%b required 0", out_valid);
      end
      flush = 0; ex_load = 0; out_ready = 1;
   endtask

   task automatic test_branch_imm();
      in_valid = 1; in_instr = I_BEQ; in_pc = 32'h300;
      rs1_data = 32'h55; rs2_data = 32'h66; wb_en = 1; wb_rd = 0; wb_data = 32'h99;
      clock_edge();
      checks++;
      if (out_imm !== 32'hFFFF_FFFC || out_wen !== 1'b0 || out_op1 !== 32'h55 || out_op2 !== 32'h66) begin
         failures++;
         $display("FAIL beq_imm_nobypass: imm=%h wen=%b op1=%h op2=%h required fffffffc/0/55/66",
                  out_imm, out_wen, out_op1, out_op2);
      end
      wb_en = 0;
   endtask

   task automatic test_reset_mid_hold();
      in_valid = 1; in_instr = I_ADDI; in_pc = 32'h400; out_ready = 1;
      clock_edge();
      out_ready = 0; in_instr = I_ADD;
      clock_edge();
      #2 rst_n = 0;
      #1;
      model_clear();
      checks++;
      if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || out_imm !== 32'd0 || out_rd !== 5'd0) begin
         failures++;
         $display("FAIL async_reset: valid=%b wen=%b pc=%h instr=%h imm=%h rd=%0d required all zero",
                  out_valid, out_wen, out_pc, out_instr, out_imm, out_rd);
      end
      #2 rst_n = 1;
      in_pc = 32'h500;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
      clock_edge();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== I_ADD || out_pc !== 32'h500) begin
         failures++;
         $display("FAIL reset_release_load: valid=%b instr=%h pc=%h required 1/%h/500",
                  out_valid, out_instr, out_pc, I_ADD);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [12];
      logic [31:0] ins;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h0F, 7'h7F};
      for (int n = 0; n < 400; n++) begin
         ins        = $urandom;
         ins[6:0]   = ops[$urandom_range(0, 11)];
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         in_instr   = ins;
         in_pc      = $urandom;
         in_valid   = ($urandom_range(0, 9) < 8);
         rs1_data   = $urandom;
         rs2_data   = $urandom;
         wb_en      = $urandom_range(0, 1) == 1;
         wb_rd      = 5'($urandom_range(0, 3));
         wb_data    = $urandom;
         ex_load    = $urandom_range(0, 2) == 0;
         ex_rd      = 5'($urandom_range(0, 3));
         flush      = $urandom_range(0, 12) == 0;
         out_ready  = $urandom_range(0, 9) < 7;
         #1;
         checks++;
         if (in_ready !== f_ready() || rs1_addr !== ins[19:15] || rs2_addr !== ins[24:20]) begin
            failures++;
            $display("FAIL rand_comb[%0d]: in_ready=%b rs1=%0d rs2=%0d required %b/%0d/%0d",
                     n, in_ready, rs1_addr, rs2_addr, f_ready(), ins[19:15], ins[24:20]);
         end
         clock_edge();
         checks++;
         if (out_valid !== m_valid || out_pc !== m_pc || out_instr !== m_instr || out_op1 !== m_op1 ||
             out_op2 !== m_op2 || out_imm !== m_imm || out_rd !== m_rd || out_wen !== m_wen) begin
            failures++;
            $display("FAIL rand_bundle[%0d]: got v=%b pc=%h i=%h o1=%h o2=%h im=%h rd=%0d w=%b required v=%b pc=%h i=%h o1=%h o2=%h im=%h rd=%0d w=%b",
                     n, out_valid, out_pc, out_instr, out_op1, out_op2, out_imm, out_rd, out_wen,
                     m_valid, m_pc, m_instr, m_op1, m_op2, m_imm, m_rd, m_wen);
         end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_bypass();
      test_load_use();
      test_hold();
      test_flush();
      test_branch_imm();
      test_reset_mid_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
